// File: rtl/mem_port_arbiter.sv
// Round-robin controller sharing a registered single-port memory between two clients.
// Sequences read/write onto the memory protocol and owns the tri-state data bus.
module mem_port_arbiter_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_data,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    rdata <= '0;
    else if (cap_en) rdata <= cap_data;
  end
endmodule

module mem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic              busy,
  output logic              mem_instruction,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data
);
  localparam int NUM_CLIENTS = 2;

  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t   [NUM_CLIENTS-1:0]             req_v;
  logic   [NUM_CLIENTS-1:0]             req_bits;
  logic   [NUM_CLIENTS-1:0]             cap_en;
  logic   [NUM_CLIENTS-1:0]             done_v;
  logic   [NUM_CLIENTS-1:0][DATA_W-1:0] rdata_v;

  state_t            state, state_nxt;
  logic              last_grant, winner, win, any_req;
  logic [DATA_W-1:0] wdata_q;

  assign req_v[0] = {we0, addr0, wdata0};
  assign req_v[1] = {we1, addr1, wdata1};
  assign req_bits = {req1, req0};

  // On a tie the client that was not served last wins.
  always_comb begin
    any_req = |req_bits;
    win     = 1'b0;
    if (&req_bits)        win = ~last_grant;
    else if (req_bits[1]) win = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = req_v[win].we ? WR : RD;
      WR:      state_nxt = DONE;
      RD:      state_nxt = RD_CAP;
      RD_CAP:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    done_v = '0;
    cap_en = '0;
    if (state == DONE)   done_v[winner] = 1'b1;
    if (state == RD_CAP) cap_en[winner] = 1'b1;
  end

  // Memory-side signals are all flops; instruction is 0 only for the single WR cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant      <= 1'b1;
      winner          <= 1'b0;
      mem_instruction <= 1'b1;
      mem_address     <= '0;
      wdata_q         <= '0;
    end else begin
      mem_instruction <= (state_nxt != WR);
      if (state == IDLE && any_req) begin
        winner      <= win;
        last_grant  <= win;
        mem_address <= req_v[win].addr;
        wdata_q     <= req_v[win].wdata;
      end
    end
  end

  assign mem_data = mem_instruction ? {DATA_W{1'bz}} : wdata_q;

  for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_lane
    mem_port_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .clock    (clock),
      .reset_n  (reset_n),
      .cap_en   (cap_en[c]),
      .cap_data (mem_data),
      .rdata    (rdata_v[c])
    );
  end

  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];
  assign done0  = done_v[0];
  assign done1  = done_v[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 4K x 16 registered memory.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic          req_r [2];
  logic          we_r  [2];
  logic [AW-1:0] addr_r[2];
  logic [DW-1:0] wdata_r[2];
  logic [DW-1:0] rdata0, rdata1;
  logic          done0, done1, busy, mem_instruction;
  logic [AW-1:0] mem_address;
  wire  [DW-1:0] mem_data;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req_r[0]), .we0(we_r[0]), .addr0(addr_r[0]), .wdata0(wdata_r[0]),
    .rdata0(rdata0), .done0(done0),
    .req1(req_r[1]), .we1(we_r[1]), .addr1(addr_r[1]), .wdata1(wdata_r[1]),
    .rdata1(rdata1), .done1(done1),
    .busy(busy), .mem_instruction(mem_instruction), .mem_address(mem_address),
    .mem_data(mem_data)
  );

  // Memory: writes on every edge with instruction = 0, else registers the addressed word.
  logic [DW-1:0] mem_arr [4096];
  logic [DW-1:0] mem_q;
  initial begin
    for (int i = 0; i < 4096; i++) mem_arr[i] = '0;
    mem_q = '0;
  end
  always @(posedge clock) begin
    if (!mem_instruction) mem_arr[mem_address] <= mem_data;
    else                  mem_q <= mem_arr[mem_address];
  end
  assign mem_data = mem_instruction ? {DW{1'bz}} : 'z;
  assign mem_data = mem_instruction ? mem_q : {DW{1'bz}};

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
    bit            chk_lat;
    bit            drop;
  } op_t;

  op_t           plan [2][$];
  op_t           exp_q[2][$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_hold[2];
  int            last_served;
  int            order_log[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  bit            mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  function automatic op_t mk(input bit we, input int addr, input int data, input int gap,
                             input bit lat, input bit drop);
    op_t o;
    o.we = we; o.addr = addr[AW-1:0]; o.data = data[DW-1:0];
    o.gap = gap; o.chk_lat = lat; o.drop = drop;
    return o;
  endfunction

  // Issue a client's planned ops; gap 0 keeps req high straight out of the done cycle.
  task automatic drive_ops(input int c);
    op_t op;
    int  k;
    bit  d;
    while (plan[c].size() != 0) begin
      op = plan[c].pop_front();
      if (op.gap > 0) begin
        req_r[c] = 1'b0;
        repeat (op.gap) @(negedge clock);
      end
      req_r[c] = 1'b1; we_r[c] = op.we; addr_r[c] = op.addr; wdata_r[c] = op.data;
      exp_q[c].push_back(op);
      k = 0;
      do begin
        @(negedge clock);
        k++;
        if (op.drop && k == 1) req_r[c] = 1'b0;
        d = (c == 0) ? done0 : done1;
      end while (!d && k < 50);
      if (!d) chk($sformatf("done_timeout_c%0d", c), 32'(d), 32'd1);
      else if (op.chk_lat) chk($sformatf("latency_c%0d_we%0d", c, op.we), k, op.we ? 2 : 3);
    end
    req_r[c] = 1'b0;
  endtask

  task automatic restart_model();
    exp_hold[0] = '0; exp_hold[1] = '0;
    last_served = 1;
    exp_q[0].delete(); exp_q[1].delete();
  endtask

  task automatic apply_reset();
    mon_en = 0;
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) req_r[c] = 1'b0;
    @(negedge clock);
    chk("rst_instr", mem_instruction, 1);
    chk("rst_addr", mem_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    @(negedge clock);
    reset_n = 1'b1;
    restart_model();
    mon_en = 1;
  endtask

  // Monitor: pops the expected op for whichever client completes and updates the reference memory.
  initial begin
    logic [1:0] dv;
    forever begin
      @(negedge clock);
      dv = {done1, done0};
      if (mon_en && reset_n && dv != 2'b00) begin
        chk("done_exclusive", 32'(dv == 2'b11), 0);
        for (int c = 0; c < 2; c++) begin
          if (dv[c]) begin
            op_t o;
            if (exp_q[c].size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL unexpected_done_c%0d: got done with no request outstanding, required none", c);
            end else begin
              o = exp_q[c].pop_front();
              if (o.we) ref_mem[int'(o.addr)] = o.data;
              else      exp_hold[c] = ref_rd(o.addr);
              last_served = c;
              order_log.push_back(c);
            end
          end
        end
        chk("rdata0", rdata0, exp_hold[0]);
        chk("rdata1", rdata1, exp_hold[1]);
        chk("bus_known", 32'($isunknown(mem_data)), 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    for (int c = 0; c < 2; c++) begin
      req_r[c] = 1'b0; we_r[c] = 1'b0; addr_r[c] = '0; wdata_r[c] = '0;
    end
    apply_reset();

    repeat (5) begin
      @(negedge clock);
      chk("idle_instr", mem_instruction, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", {done1, done0}, 0);
    end

    plan[0].push_back(mk(1, 'h1A1, 81, 1, 1, 0));
    plan[0].push_back(mk(0, 'h1A1, 0, 1, 1, 0));
    drive_ops(0);
    chk("rd_1a1_81", rdata0, 81);

    apply_reset();
    order_log.delete();
    plan[0].push_back(mk(1, 'h123, 43, 1, 0, 0));
    plan[1].push_back(mk(1, 'h1A1, 24, 1, 0, 0));
    fork drive_ops(0); drive_ops(1); join
    chk("tie_count", order_log.size(), 2);
    if (order_log.size() >= 2) begin
      chk("tie_first", order_log[0], 0);
      chk("tie_second", order_log[1], 1);
    end
    plan[0].push_back(mk(0, 'h123, 0, 1, 1, 0));
    drive_ops(0);
    chk("rd_123_43", rdata0, 43);
    plan[1].push_back(mk(0, 'h1A1, 0, 1, 1, 0));
    drive_ops(1);
    chk("rd_1a1_24", rdata1, 24);

    first = 1 - last_served;
    order_log.delete();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 3; i++)
        plan[c].push_back(mk(i % 2 == 0, 'h300 + 4 * c + i, $urandom, (i == 0) ? 1 : 0, 0, 0));
    fork drive_ops(0); drive_ops(1); join
    chk("alt_count", order_log.size(), 6);
    if (order_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("alt_%0d", i), order_log[i], (first + i) % 2);

    plan[1].push_back(mk(1, 'h2AB, 'hBEEF, 1, 1, 1));
    plan[1].push_back(mk(0, 'h2AB, 0, 1, 1, 1));
    drive_ops(1);
    chk("drop_rd", rdata1, 'hBEEF);

    plan[0].push_back(mk(1, 'h123, 74, 1, 0, 0));
    plan[1].push_back(mk(0, 'h123, 0, 2, 0, 0));
    fork drive_ops(0); drive_ops(1); join
    chk("rd_after_wr_74", rdata1, 74);

    @(negedge clock);
    req_r[0] = 1'b1; we_r[0] = 1'b1; addr_r[0] = 'h1A1; wdata_r[0] = 35;
    @(negedge clock);
    chk("wr_instr", mem_instruction, 0);
    chk("wr_addr", mem_address, 'h1A1);
    chk("wr_busy", busy, 1);
    #2;
    mon_en = 0;
    reset_n = 1'b0;
    #1;
    chk("arst_instr", mem_instruction, 1);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_address, 0);
    chk("arst_done", {done1, done0}, 0);
    req_r[0] = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    restart_model();
    mon_en = 1;
    plan[0].push_back(mk(0, 'h1A1, 0, 1, 1, 0));
    drive_ops(0);
    chk("rd_1a1_after_abort", rdata0, 24);

    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 15; i++) begin
        int a, d, sel;
        sel = $urandom_range(0, 4);
        case (sel)
          0: a = 'hFFF;
          1: a = 0;
          2: a = 'h123;
          3: a = 'h1A1;
          default: a = $urandom_range(0, 4095);
        endcase
        d = ($urandom_range(0, 3) == 0) ? 'hFFFF : $urandom_range(0, 65535);
        plan[c].push_back(mk($urandom_range(0, 1) == 1, a, d, $urandom_range(0, 3), 0, 0));
      end
    fork drive_ops(0); drive_ops(1); join

    repeat (5) @(negedge clock);
    chk("pending_c0", exp_q[0].size(), 0);
    chk("pending_c1", exp_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller for the shared single-port 4K x 16 memory. The memory has a `clock`, an `instruction` input (1 = read, 0 = write), a 12-bit address and a 16-bit inout data bus.
- Sequences each read and write onto the memory's registered protocol.
- Shares the memory fairly between two clients (round-robin).
- Owns the memory-side tri-state bus so the memory and controller never drive it at the same time.

Parameters:
- ADDR_W, 12, memory address width
- DATA_W, 16, memory data width

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0  in  1  client 0 request; hold high until done0
- we0  in  1  client 0 op: 1 = write, 0 = read; sampled with req0
- addr0  in  ADDR_W  client 0 address; sampled at grant
- wdata0  in  DATA_W  client 0 write data; sampled at grant
- rdata0  out  DATA_W  client 0 read result; valid when done0 is high
- done0  out  1  one-cycle completion pulse to client 0
- req1, we1, addr1, wdata1, rdata1, done1  same as client 0, for client 1
- busy  out  1  high in any state other than IDLE
- mem_instruction  out  1  to memory: 1 = read, 0 = write
- mem_address  out  ADDR_W  to memory address
- mem_data  inout  DATA_W  memory data bus

Behaviour:
- Reset values (asynchronous, immediate on reset_n low):
  - state = IDLE, mem_instruction = 1, mem_address = 0
  - mem_data released (Z); rdata0 = rdata1 = 0; done0 = done1 = 0; busy = 0
  - last_grant = 1, so client 0 wins the first tie
- Memory-side outputs (mem_instruction, mem_address, write-data latch) are registered flops; there is no combinational path from req/addr to the memory.
- Bus ownership: controller drives mem_data = wdata latch only when the mem_instruction flop is 0, otherwise Z. The drive enable comes from that same flop, so ownership switches in the same delta as the memory's own enable.
- Idle is a read: the memory writes on every edge where instruction = 0. In every non-WR state mem_instruction stays 1, so there are no spurious writes.
- States:
  - IDLE: arbitrate.
    - Only one req high: grant it.
    - Both high: grant the client not equal to last_grant.
    - On grant: latch addr, we and wdata of the winner; set last_grant.
    - Next state is WR if we = 1, else RD.
    - On the WR transition, register mem_instruction = 0 and mem_address = addr. On the RD transition, register mem_instruction = 1 and mem_address = addr.
  - WR (1 cycle): memory writes on the closing edge. Next state is DONE, with mem_instruction returning to 1.
  - RD (1 cycle): memory loads its output register on the closing edge. Next state is RD_CAP.
  - RD_CAP (1 cycle): capture mem_data into the winner's rdata on the closing edge. Next state is DONE.
  - DONE (1 cycle): winner's done is high. No arbitration happens in this state. Next state is IDLE.
- Latency, counted from the edge that samples req in IDLE:
  - write: done high in cycle 2, IDLE in cycle 3
  - read: done high in cycle 3, IDLE in cycle 4
  - back-to-back same client: new op granted at the edge after DONE, giving a 3-cycle write / 4-cycle read period
- The non-winning client's rdata holds its old value; its done stays 0.
- Client rules: requester drops req during its done cycle. A req still high in IDLE starts a new operation.
- req dropped mid-operation: the operation still completes and done still pulses.
- addr/wdata changes after grant are ignored.
- Reset asserted in WR before the write edge: mem_instruction goes to 1 asynchronously, so no write occurs and the bus is released. Reset in RD or RD_CAP: rdata is not updated.
- Address 0xFFF and data 0xFFFF pass through unmodified; no wrap or arithmetic is applied.

Test Plan:
- Reset, then idle 5 cycles -> mem_instruction = 1, mem_data never driven by the controller, no done, busy = 0.
- Client 0 write 0x1A1 <= 81, then client 0 read 0x1A1 -> done0 two cycles after write grant; rdata0 = 81 with done0 three cycles after read grant.
- req0 and req1 high on the same edge: write 0x123 <= 43 and write 0x1A1 <= 24 -> client 0 served first, then client 1. Readback: 0x123 = 43, 0x1A1 = 24.
- Both clients hold req continuously for 6 operations -> grants alternate 0,1,0,1,0,1; done never high for both clients at once.
- Write 0x123 <= 74 immediately followed by read 0x123 from the other client -> rdata1 = 74; no X on mem_data at any time; controller driver and memory driver never both enabled.
- reset_n pulsed low during WR of 0x1A1 <= 35 (prior value 24) -> outputs return to reset values at once; a later read of 0x1A1 returns 24.
